// File: rtl/axis_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_fifo_pkg
//  Description : Shared width helpers and parameter legality checks for the
//                parametrised AXI4-Stream FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_fifo_pkg;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Number of TSTRB bits for a given TDATA width.
    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

    // Width of one stored entry {tlast, tstrb, tdata}.
    function automatic int entry_width(input int data_width);
        return 1 + strb_width(data_width) + data_width;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // True when the parameter set describes a buildable FIFO.
    function automatic bit params_legal(input int data_width, input int depth,
                                        input int thresh);
        return (data_width >= 8) && ((data_width % 8) == 0) &&
               (depth >= 2) && is_pow2(depth) &&
               (thresh >= 1) && (thresh <= depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : axis_fifo_ram
//  Description : Storage array for the stream FIFO. Synchronous write port,
//                asynchronous read port; contents are never reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_fifo_ram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 2,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the accepted word into its slot.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem_q[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/axis_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : axis_fifo_param
//  Description : Parametrised single-clock AXI4-Stream FIFO with TSTRB/TLAST,
//                exact full/empty, fill level, almost-full and first-word
//                fall-through output.
//                Define AXIS_FIFO_PACKET_MODE_EN for store-and-forward:
//                output is held back until a complete packet is stored
//                (or the FIFO is full, which forces cut-through).
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_fifo_param
    import axis_fifo_pkg::*;
#(
    parameter int DATA_WIDTH         = 32,
    parameter int DEPTH              = 32,
    parameter int ALMOST_FULL_THRESH = DEPTH - 4
) (
    input  logic                    clock,
    input  logic                    resetN,
    input  logic [DATA_WIDTH-1:0]   dataIn,
    input  logic                    dataInTValid,
    output logic                    dataInTReady,
    input  logic                    dataInTLast,
    input  logic [DATA_WIDTH/8-1:0] dataInTStrb,
    output logic [DATA_WIDTH-1:0]   dataOut,
    output logic                    dataOutTValid,
    input  logic                    dataOutTReady,
    output logic                    dataOutTLast,
    output logic [DATA_WIDTH/8-1:0] dataOutTStrb,
    output logic [$clog2(DEPTH):0]  fillLevel,
    output logic                    almostFull
);

    localparam int c_ADDR_W  = $clog2(DEPTH);
    localparam int c_PTR_W   = ptr_width(DEPTH);
    localparam int c_STRB_W  = strb_width(DATA_WIDTH);
    localparam int c_ENTRY_W = entry_width(DATA_WIDTH);

    localparam logic [c_PTR_W-1:0] c_ONE    = c_PTR_W'(1);
    localparam logic [c_PTR_W-1:0] c_DEPTH  = c_PTR_W'(DEPTH);
    localparam logic [c_PTR_W-1:0] c_THRESH = c_PTR_W'(ALMOST_FULL_THRESH);

    typedef struct packed {
        logic                tlast;
        logic [c_STRB_W-1:0] tstrb;
        logic [DATA_WIDTH-1:0] tdata;
    } fifo_entry_t;

    // Refuse to elaborate an unusable configuration.
    if (!params_legal(DATA_WIDTH, DEPTH, ALMOST_FULL_THRESH)) begin : g_param_check
        $error("axis_fifo_param: illegal DATA_WIDTH/DEPTH/ALMOST_FULL_THRESH");
    end

    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W-1:0] fill_q, fill_d;
    logic               in_ready_q, in_ready_d;
    logic               almost_full_q, almost_full_d;

    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_out_valid;
    fifo_entry_t        w_wr_entry;
    fifo_entry_t        w_rd_entry;
    logic [c_ENTRY_W-1:0] w_rd_data;

    assign w_wr_entry = '{tlast: dataInTLast, tstrb: dataInTStrb, tdata: dataIn};
    assign w_rd_entry = fifo_entry_t'(w_rd_data);

    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_push  = dataInTValid && in_ready_q;
    assign w_pop   = w_out_valid && dataOutTReady;

    axis_fifo_ram #(
        .WIDTH  (c_ENTRY_W),
        .DEPTH  (DEPTH),
        .ADDR_W (c_ADDR_W)
    ) u_ram (
        .clk       (clock),
        .i_wr_en   (w_push),
        .i_wr_addr (wr_ptr_q[c_ADDR_W-1:0]),
        .i_wr_data (w_wr_entry),
        .i_rd_addr (rd_ptr_q[c_ADDR_W-1:0]),
        .o_rd_data (w_rd_data)
    );

`ifdef AXIS_FIFO_PACKET_MODE_EN
    logic [c_PTR_W-1:0] pkt_count_q, pkt_count_d;
    logic               w_full;
    logic               w_push_last;
    logic               w_pop_last;

    assign w_full = (wr_ptr_q[c_ADDR_W-1:0] == rd_ptr_q[c_ADDR_W-1:0]) &&
                    (wr_ptr_q[c_ADDR_W] != rd_ptr_q[c_ADDR_W]);

    // Full forces cut-through so a packet longer than DEPTH cannot deadlock.
    assign w_out_valid = !w_empty && ((pkt_count_q != '0) || w_full);

    assign w_push_last = w_push && dataInTLast;
    assign w_pop_last  = w_pop && w_rd_entry.tlast;

    // Track how many complete packets are currently stored.
    always_comb begin
        pkt_count_d = pkt_count_q;
        if (w_push_last && !w_pop_last) begin
            pkt_count_d = pkt_count_q + c_ONE;
        end else if (w_pop_last && !w_push_last) begin
            pkt_count_d = pkt_count_q - c_ONE;
        end
    end

    // Packet counter register; stored packets are discarded on reset.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            pkt_count_q <= '0;
        end else begin
            pkt_count_q <= pkt_count_d;
        end
    end
`else
    assign w_out_valid = !w_empty;
`endif

    // Next pointer, fill and registered status values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_ONE;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ONE;
        end
        case ({w_push, w_pop})
            2'b10:   fill_d = fill_q + c_ONE;
            2'b01:   fill_d = fill_q - c_ONE;
            default: fill_d = fill_q;
        endcase
        in_ready_d    = !(fill_d == c_DEPTH);
        almost_full_d = (fill_d >= c_THRESH);
    end

    // State registers; ready stays low during reset and rises one edge after.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fill_q        <= '0;
            in_ready_q    <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fill_q        <= fill_d;
            in_ready_q    <= in_ready_d;
            almost_full_q <= almost_full_d;
        end
    end

    assign dataInTReady  = in_ready_q;
    assign fillLevel     = fill_q;
    assign almostFull    = almost_full_q;
    assign dataOutTValid = w_out_valid;
    assign dataOut       = w_out_valid ? w_rd_entry.tdata : '0;
    assign dataOutTStrb  = w_out_valid ? w_rd_entry.tstrb : '0;
    assign dataOutTLast  = w_out_valid ? w_rd_entry.tlast : 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_axis_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_fifo_param
//  Description : Directed and randomised self-checking bench for
//                axis_fifo_param (DATA_WIDTH 32, DEPTH 32, threshold 28).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_fifo_param;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int TH    = 28;
    localparam int SW    = DW / 8;
`ifdef AXIS_FIFO_PACKET_MODE_EN
    localparam bit PKT = 1'b1;
`else
    localparam bit PKT = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          resetN;
    logic [DW-1:0] dataIn;
    logic          dataInTValid;
    logic          dataInTReady;
    logic          dataInTLast;
    logic [SW-1:0] dataInTStrb;
    logic [DW-1:0] dataOut;
    logic          dataOutTValid;
    logic          dataOutTReady;
    logic          dataOutTLast;
    logic [SW-1:0] dataOutTStrb;
    logic [5:0]    fillLevel;
    logic          almostFull;

    int n_chk  = 0;
    int n_pass = 0;

    axis_fifo_param #(
        .DATA_WIDTH         (DW),
        .DEPTH              (DEPTH),
        .ALMOST_FULL_THRESH (TH)
    ) dut (
        .clock         (clock),
        .resetN        (resetN),
        .dataIn        (dataIn),
        .dataInTValid  (dataInTValid),
        .dataInTReady  (dataInTReady),
        .dataInTLast   (dataInTLast),
        .dataInTStrb   (dataInTStrb),
        .dataOut       (dataOut),
        .dataOutTValid (dataOutTValid),
        .dataOutTReady (dataOutTReady),
        .dataOutTLast  (dataOutTLast),
        .dataOutTStrb  (dataOutTStrb),
        .fillLevel     (fillLevel),
        .almostFull    (almostFull)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
        dataIn       = d;
        dataInTStrb  = s;
        dataInTLast  = l;
        dataInTValid = 1'b1;
        tick();
        dataInTValid = 1'b0;
    endtask

    // Random-phase scoreboard: entries are {tlast, tstrb, tdata}.
    logic [36:0] q[$];

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pushed, cycles, maxfill, pkt, cnt;
        logic v, r, l, exp_valid, exp_ready, do_push, do_pop;
        logic [DW-1:0] d;
        logic [SW-1:0] s;

        resetN = 1'b0;
        dataIn = '0; dataInTValid = 1'b0; dataInTLast = 1'b0; dataInTStrb = '0;
        dataOutTReady = 1'b0;

        // Reset values
        #1;
        chk("rst_ready", dataInTReady, 0);
        chk("rst_valid", dataOutTValid, 0);
        chk("rst_fill", fillLevel, 0);
        chk("rst_afull", almostFull, 0);
        chk("rst_data", dataOut, 0);
        repeat (2) @(posedge clock);
        #2 resetN = 1'b1;
        #1 chk("rel_ready_low", dataInTReady, 0);
        tick();
        chk("rel_ready_high", dataInTReady, 1);
        chk("rel_fill", fillLevel, 0);

        // Push 1..5 with no pops
        for (int i = 1; i <= 5; i++) begin
            push_word(DW'(i), SW'(i), 1'b0);
            if (i == 1) chk("first_word_valid", dataOutTValid, PKT ? 0 : 1);
        end
        chk("t1_fill", fillLevel, 5);
        chk("t1_valid", dataOutTValid, PKT ? 0 : 1);
        chk("t1_data", dataOut, PKT ? 0 : 1);
        chk("t1_strb", dataOutTStrb, PKT ? 0 : 1);

        // Fill to DEPTH, watch almost-full threshold
        for (int i = 6; i <= 32; i++) begin
            push_word(DW'(i), SW'(i), 1'b0);
            if (i == 27) chk("afull_at27", almostFull, 0);
            if (i == 28) chk("afull_at28", almostFull, 1);
            if (i == 31) chk("ready_at31", dataInTReady, 1);
        end
        chk("full_ready", dataInTReady, 0);
        chk("full_fill", fillLevel, 32);
        chk("full_valid", dataOutTValid, 1);
        chk("full_data", dataOut, 1);

        // 33rd word is held while full
        dataIn = 32'd33; dataInTStrb = 4'hF; dataInTLast = 1'b1; dataInTValid = 1'b1;
        tick(); tick();
        chk("held_fill", fillLevel, 32);
        chk("held_ready", dataInTReady, 0);
        dataOutTReady = 1'b1;
        tick();
        dataOutTReady = 1'b0;
        chk("popfull_ready", dataInTReady, 1);
        chk("popfull_fill", fillLevel, 31);
        tick();
        dataInTValid = 1'b0;
        chk("held_accept_fill", fillLevel, 32);
        chk("held_accept_data", dataOut, 2);

        // Drain in order, TLAST only on word 33
        dataOutTReady = 1'b1;
        for (int i = 2; i <= 33; i++) begin
            chk("drain", {dataOutTValid, dataOutTLast, dataOut}, {1'b1, (i == 33), 32'(i)});
            tick();
        end
        dataOutTReady = 1'b0;
        chk("drain_fill", fillLevel, 0);
        chk("drain_valid", dataOutTValid, 0);
        chk("drain_afull", almostFull, 0);

        // 4-word packet, TLAST on word 4
        for (int i = 0; i < 4; i++) begin
            push_word(32'hA0 + 32'(i), 4'hF, (i == 3));
            chk("pkt_valid", dataOutTValid, PKT ? (i == 3) : 1);
        end
        dataOutTReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("pkt_pop", {dataOutTValid, dataOutTLast, dataOut},
                {1'b1, (i == 3), 32'hA0 + 32'(i)});
            tick();
        end
        chk("pkt_done_valid", dataOutTValid, 0);

        // Simultaneous push/pop at fill level 1
        dataIn = 32'hB0; dataInTStrb = 4'h3; dataInTLast = 1'b1; dataInTValid = 1'b1;
        tick();
        chk("pp_fill0", fillLevel, 1);
        chk("pp_data0", dataOut, 32'hB0);
        dataIn = 32'hB1;
        tick();
        chk("pp_fill1", fillLevel, 1);
        chk("pp_data1", dataOut, 32'hB1);
        dataIn = 32'hB2;
        tick();
        chk("pp_fill2", fillLevel, 1);
        chk("pp_data2", {dataOutTStrb, dataOut}, {4'h3, 32'hB2});
        dataInTValid = 1'b0;
        tick();
        dataOutTReady = 1'b0;
        chk("pp_empty", {dataOutTValid, fillLevel, dataOut}, 0);

        // Random traffic, 10000 words
        pushed = 0; cycles = 0; maxfill = 0; pkt = 0; cnt = 0;
        while ((pushed < 10000 || q.size() > 0) && cycles < 60000) begin
            v = (pushed < 10000) && ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 7);
            d = $urandom;
            s = SW'($urandom_range(0, 15));
            l = ($urandom_range(0, 7) == 0) || (pushed == 9999);
            dataIn = d; dataInTStrb = s; dataInTLast = l;
            dataInTValid = v; dataOutTReady = r;
            exp_ready = (cnt != DEPTH);
            exp_valid = (cnt != 0) && (!PKT || pkt != 0 || cnt == DEPTH);
            chk("rnd_valid", dataOutTValid, exp_valid);
            chk("rnd_status", {dataInTReady, almostFull, fillLevel},
                {exp_ready, (cnt >= TH), 6'(cnt)});
            chk("rnd_data", {dataOutTLast, dataOutTStrb, dataOut}, exp_valid ? q[0] : 37'd0);
            do_push = v && exp_ready;
            do_pop  = exp_valid && r;
            tick();
            if (do_pop) begin
                if (q[0][36]) pkt--;
                void'(q.pop_front());
            end
            if (do_push) begin
                q.push_back({l, s, d});
                if (l) pkt++;
                pushed++;
            end
            cnt = q.size();
            if (cnt > maxfill) maxfill = cnt;
            cycles++;
        end
        dataInTValid = 1'b0; dataOutTReady = 1'b0;
        chk("rnd_complete", {32'(pushed), 32'(q.size())}, {32'd10000, 32'd0});
        chk("rnd_maxfill_ok", (maxfill <= DEPTH), 1);
        chk("rnd_end_fill", fillLevel, 0);

        // Reset mid-stream at fill level 10
        for (int i = 0; i < 10; i++) push_word(32'hC0 + 32'(i), 4'hF, 1'b1);
        chk("t6_fill", fillLevel, 10);
        dataIn = 32'hCA; dataInTValid = 1'b1;
        #2 resetN = 1'b0;
        #1;
        chk("t6_async_out", {dataOutTValid, dataOutTLast, dataOutTStrb, dataOut}, 0);
        chk("t6_async_status", {dataInTReady, almostFull, fillLevel}, 0);
        @(posedge clock);
        #2 resetN = 1'b1;
        dataInTValid = 1'b0;
        #1 chk("t6_rel_ready_low", dataInTReady, 0);
        tick();
        chk("t6_rel_ready", dataInTReady, 1);
        chk("t6_rel_fill_valid", {fillLevel, dataOutTValid}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
